// File: rtl/dds_pkg.sv
// Shared types for the DDS frequency-sweep controller.
package dds_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    UP   = 2'b01,
    DOWN = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    MODE_SINGLE = 2'b00,
    MODE_SAW    = 2'b01,
    MODE_TRI    = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_t;

endpackage

// File: rtl/dds_dwell_timer.sv
// Dwell down-counter: loaded per frequency value, expires when it reaches zero.
module dds_dwell_timer #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expire
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && cnt != '0) begin
      cnt <= cnt - {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign expire = en && (cnt == '0);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency sweep controller: single-up, sawtooth or triangle sweeps of a DDS
// frequency word with per-value dwell, clamped at the configured bounds.
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int unsigned FW  = 32,
  parameter int unsigned DWW = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           abort,
  input  logic [1:0]     mode,
  input  logic [FW-1:0]  f_start,
  input  logic [FW-1:0]  f_stop,
  input  logic [FW-1:0]  f_step,
  input  logic [DWW-1:0] dwell,
  output logic [FW-1:0]  Fcword,
  output logic           busy,
  output logic           done,
  output logic           wrap,
  output logic           cfg_err
);

  state_t         state, state_nxt;
  mode_t          mode_r;
  logic [FW-1:0]  f_start_r, f_stop_r, f_step_r;
  logic [DWW-1:0] dwell_r;

  logic           cfg_ok, start_req, accept, reject, expire, tmr_load, sweeping;
  logic [DWW-1:0] tmr_val;
  logic [FW:0]    up_sum, dn_diff;
  logic [FW-1:0]  up_val, dn_val;
  logic [FW-1:0]  fc_nxt;
  logic           busy_nxt, done_nxt, wrap_nxt;

  assign cfg_ok    = (f_step != '0) && (f_start <= f_stop) && (mode != MODE_RSVD);
  assign start_req = (state == IDLE) && start && !abort;
  assign accept    = start_req && cfg_ok;
  assign reject    = start_req && !cfg_ok;
  assign sweeping  = (state != IDLE);

  // One extra bit catches carry/borrow so clamping also covers wrap-around.
  assign up_sum  = {1'b0, Fcword} + {1'b0, f_step_r};
  assign dn_diff = {1'b0, Fcword} - {1'b0, f_step_r};
  assign up_val  = (up_sum > {1'b0, f_stop_r}) ? f_stop_r : up_sum[FW-1:0];
  assign dn_val  = (dn_diff[FW] || (dn_diff[FW-1:0] < f_start_r)) ? f_start_r : dn_diff[FW-1:0];

  assign tmr_load = accept || (sweeping && expire && !abort);
  assign tmr_val  = accept ? dwell : dwell_r;

  dds_dwell_timer #(.W(DWW)) u_dwell (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (sweeping),
    .expire   (expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = UP;
      UP: begin
        if (abort) state_nxt = IDLE;
        else if (expire && Fcword == f_stop_r) begin
          case (mode_r)
            MODE_SAW: state_nxt = UP;
            MODE_TRI: state_nxt = DOWN;
            default:  state_nxt = IDLE;
          endcase
        end
      end
      DOWN: begin
        if (abort) state_nxt = IDLE;
        else if (expire && Fcword == f_start_r) state_nxt = UP;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    fc_nxt   = Fcword;
    done_nxt = 1'b0;
    wrap_nxt = 1'b0;
    busy_nxt = (state_nxt != IDLE);
    case (state)
      IDLE: if (accept) fc_nxt = f_start;
      UP: begin
        if (!abort && expire) begin
          if (Fcword == f_stop_r) begin
            case (mode_r)
              MODE_SAW: begin fc_nxt = f_start_r; wrap_nxt = 1'b1; end
              MODE_TRI: begin fc_nxt = dn_val;    wrap_nxt = 1'b1; end
              default:  done_nxt = 1'b1;
            endcase
          end else begin
            fc_nxt = up_val;
          end
        end
      end
      DOWN: begin
        if (!abort && expire) begin
          if (Fcword == f_start_r) begin
            fc_nxt   = up_val;
            wrap_nxt = 1'b1;
          end else begin
            fc_nxt = dn_val;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Fcword    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      wrap      <= 1'b0;
      cfg_err   <= 1'b0;
      mode_r    <= MODE_SINGLE;
      f_start_r <= '0;
      f_stop_r  <= '0;
      f_step_r  <= '0;
      dwell_r   <= '0;
    end else begin
      Fcword  <= fc_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      wrap    <= wrap_nxt;
      cfg_err <= reject;
      if (accept) begin
        mode_r    <= mode_t'(mode);
        f_start_r <= f_start;
        f_stop_r  <= f_stop;
        f_step_r  <= f_step;
        dwell_r   <= dwell;
      end
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl: directed sweeps, error/abort/reset
// scenarios, and randomized sweeps against a sequence-level reference model.
module tb_dds_sweep_ctrl;

  localparam int unsigned FW  = 32;
  localparam int unsigned DWW = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic [1:0]     mode = '0;
  logic [FW-1:0]  f_start = '0, f_stop = '0, f_step = '0;
  logic [DWW-1:0] dwell = '0;
  logic [FW-1:0]  Fcword;
  logic           busy, done, wrap, cfg_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dds_sweep_ctrl #(.FW(FW), .DWW(DWW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .mode    (mode),
    .f_start (f_start),
    .f_stop  (f_stop),
    .f_step  (f_step),
    .dwell   (dwell),
    .Fcword  (Fcword),
    .busy    (busy),
    .done    (done),
    .wrap    (wrap),
    .cfg_err (cfg_err)
  );

  task automatic scramble_inputs();
    mode    = 2'($urandom_range(0, 3));
    f_start = $urandom;
    f_stop  = $urandom;
    f_step  = $urandom;
    dwell   = 16'($urandom_range(0, 65535));
  endtask

  // Expected trace: list of frequency values (with wrap-on-entry flags), each
  // held dwell+1 cycles; single-up then one done cycle and idle.
  task automatic run_sweep(input string name, input logic [1:0] m,
                           input logic [31:0] fs, input logic [31:0] fe,
                           input logic [31:0] st, input logic [15:0] dw,
                           input int unsigned cont_cycles, input bit poke);
    longint      vals[$];
    bit          wr[$];
    longint      v, lo, hi, s;
    bit          up, w;
    int unsigned hold, maxn, busy_cyc, ncyc, poke_k, idx, ph;
    logic [35:0] exp_v, act_v;
    hold = int'(dw) + 1;
    lo = longint'(fs); hi = longint'(fe); s = longint'(st);
    v = lo; up = 1'b1;
    maxn = (m == 2'd0) ? 100000 : cont_cycles / hold + 2;
    vals.push_back(v); wr.push_back(1'b0);
    while (vals.size() < maxn) begin
      if (up && v == hi) begin
        if (m == 2'd0) break;
        else if (m == 2'd1) v = lo;
        else begin up = 1'b0; v = (v - s < lo) ? lo : v - s; end
        w = 1'b1;
      end else if (up) begin
        v = (v + s > hi) ? hi : v + s; w = 1'b0;
      end else if (v == lo) begin
        up = 1'b1; v = (v + s > hi) ? hi : v + s; w = 1'b1;
      end else begin
        v = (v - s < lo) ? lo : v - s; w = 1'b0;
      end
      vals.push_back(v); wr.push_back(w);
    end
    busy_cyc = (m == 2'd0) ? vals.size() * hold : cont_cycles;
    ncyc     = (m == 2'd0) ? busy_cyc + 3 : cont_cycles;
    poke_k   = $urandom_range(0, busy_cyc - 1);

    @(negedge clk);
    mode = m; f_start = fs; f_stop = fe; f_step = st; dwell = dw; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    scramble_inputs();
    for (int unsigned k = 0; k < ncyc; k++) begin
      idx = k / hold;
      ph  = k % hold;
      if (idx < vals.size())
        exp_v = {vals[idx][31:0], 1'b1, 1'b0, (ph == 0) && wr[idx], 1'b0};
      else
        exp_v = {vals[vals.size()-1][31:0], 1'b0, k == busy_cyc, 1'b0, 1'b0};
      act_v = {Fcword, busy, done, wrap, cfg_err};
      tests++;
      if (act_v !== exp_v) begin
        fails++;
        $display("FAIL %s k=%0d got fc=%h busy=%b done=%b wrap=%b err=%b, expected fc=%h busy=%b done=%b wrap=%b err=%b",
                 name, k, act_v[35:4], act_v[3], act_v[2], act_v[1], act_v[0],
                 exp_v[35:4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
      end
      if (poke && k == poke_k) begin
        start = 1'b1;
        scramble_inputs();
      end
      @(negedge clk);
      start = 1'b0;
    end
    if (m != 2'd0) begin
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      tests++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        fails++;
        $display("FAIL %s_end_abort got busy=%b done=%b, expected busy=0 done=0", name, busy, done);
      end
    end
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if ({Fcword, busy, done, wrap, cfg_err} !== 36'd0) begin
      fails++;
      $display("FAIL reset_during got fc=%h busy=%b done=%b wrap=%b err=%b, expected all 0",
               Fcword, busy, done, wrap, cfg_err);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if ({Fcword, busy, done, wrap, cfg_err} !== 36'd0) begin
      fails++;
      $display("FAIL reset_after got fc=%h busy=%b done=%b wrap=%b err=%b, expected all 0",
               Fcword, busy, done, wrap, cfg_err);
    end
  endtask

  task automatic test_single_exact();
    run_sweep("single_exact", 2'd0, 32'd100, 32'd400, 32'd100, 16'd2, 0, 1'b0);
  endtask

  task automatic test_single_clamp();
    run_sweep("single_clamp", 2'd0, 32'd100, 32'd350, 32'd100, 16'd0, 0, 1'b0);
  endtask

  // Runs while idle with Fcword left at 350 by the clamped single sweep.
  task automatic test_cfg_err();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      mode = 2'd0; f_start = 32'd10; f_stop = 32'd20; f_step = 32'd5; dwell = 16'd0;
      case (c)
        0: f_step = 32'd0;
        1: begin f_start = 32'd30; f_stop = 32'd20; end
        2: mode = 2'd3;
        default: ;
      endcase
      start = (c != 4);
      abort = (c >= 3);
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      tests++;
      if ({Fcword, busy, cfg_err, done, wrap} !== {32'd350, 1'b0, c < 3, 1'b0, 1'b0}) begin
        fails++;
        $display("FAIL cfg_err_case%0d got fc=%h busy=%b err=%b done=%b wrap=%b, expected fc=%h busy=0 err=%b",
                 c, Fcword, busy, cfg_err, done, wrap, 32'd350, c < 3);
      end
      @(negedge clk);
      tests++;
      if ({busy, cfg_err} !== 2'b00) begin
        fails++;
        $display("FAIL cfg_err_pulse%0d got busy=%b err=%b, expected 0 0", c, busy, cfg_err);
      end
    end
  endtask

  task automatic test_triangle();
    run_sweep("triangle", 2'd2, 32'd0, 32'd20, 32'd10, 16'd0, 30, 1'b0);
  endtask

  task automatic test_saw_overflow();
    run_sweep("saw_overflow", 2'd1, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 16'd1, 12, 1'b0);
  endtask

  task automatic test_equal_bounds();
    run_sweep("equal_tri", 2'd2, 32'd500, 32'd500, 32'd7, 16'd1, 12, 1'b0);
    run_sweep("equal_saw", 2'd1, 32'd500, 32'd500, 32'd7, 16'd0, 8, 1'b0);
    run_sweep("equal_single", 2'd0, 32'd500, 32'd500, 32'd7, 16'd3, 0, 1'b0);
  endtask

  task automatic test_abort();
    bit found = 1'b0;
    @(negedge clk);
    mode = 2'd1; f_start = 32'd100; f_stop = 32'd1000; f_step = 32'd50; dwell = 16'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (Fcword === 32'd200) begin found = 1'b1; break; end
      @(negedge clk);
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL abort_wait got fc=%h, expected fc=%h within 30 cycles", Fcword, 32'd200);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    tests++;
    if ({Fcword, busy, done, wrap} !== {32'd200, 3'b000}) begin
      fails++;
      $display("FAIL abort_next got fc=%h busy=%b done=%b wrap=%b, expected fc=%h busy=0 done=0 wrap=0",
               Fcword, busy, done, wrap, 32'd200);
    end
    repeat (4) @(negedge clk);
    tests++;
    if ({Fcword, busy, done} !== {32'd200, 2'b00}) begin
      fails++;
      $display("FAIL abort_hold got fc=%h busy=%b done=%b, expected fc=%h busy=0 done=0",
               Fcword, busy, done, 32'd200);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    mode = 2'd1; f_start = 32'd1000; f_stop = 32'd5000; f_step = 32'd300; dwell = 16'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if ({Fcword, busy, done, wrap} !== 35'd0) begin
      fails++;
      $display("FAIL reset_mid got fc=%h busy=%b done=%b wrap=%b, expected all 0", Fcword, busy, done, wrap);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep("post_reset", 2'd0, 32'd100, 32'd400, 32'd100, 16'd2, 0, 1'b0);
  endtask

  // Random configs, including near-top frequencies, with a start poked mid-sweep.
  task automatic test_random();
    logic [1:0]  m;
    logic [31:0] fs, fe, st;
    logic [15:0] dw;
    int unsigned span;
    for (int it = 0; it < 25; it++) begin
      m    = 2'($urandom_range(0, 2));
      fs   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FF00 + $urandom_range(0, 255) : $urandom;
      span = $urandom_range(0, 600);
      fe   = (longint'(fs) + span > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : fs + span;
      span = fe - fs;
      st   = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 32'hFFFF_FFFF)
                                         : $urandom_range(span / 8 + 1, span / 2 + 1);
      dw   = 16'($urandom_range(0, 3));
      run_sweep($sformatf("random%0d", it), m, fs, fe, st, dw, 40, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_single_exact();
    test_single_clamp();
    test_cfg_err();
    test_triangle();
    test_saw_overflow();
    test_equal_bounds();
    test_abort();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dds_sweep_ctrl.md
DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

Interface
REQ-001 SHALL have parameter FW, default 32, frequency-control-word width.
REQ-002 SHALL have parameter DWW, default 16, dwell-counter width.
REQ-003 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  single-cycle sweep start request.
REQ-006 SHALL have port abort  input  1  single-cycle sweep cancel request.
REQ-007 SHALL have port mode  input  2  00 single-up, 01 continuous sawtooth, 10 continuous triangle, 11 reserved.
REQ-008 SHALL have port f_start  input  FW  first (lowest) frequency word.
REQ-009 SHALL have port f_stop  input  FW  last (highest) frequency word.
REQ-010 SHALL have port f_step  input  FW  increment per step.
REQ-011 SHALL have port dwell  input  DWW  hold time per frequency, minus one, in clk cycles.
REQ-012 SHALL have port Fcword  output  FW  registered frequency word driving the DDS phase accumulator.
REQ-013 SHALL have port busy  output  1  high while sweeping.
REQ-014 SHALL have port done  output  1  one-cycle pulse at single-up completion.
REQ-015 SHALL have port wrap  output  1  one-cycle pulse at each continuous-mode end-of-sweep turnaround or restart.
REQ-016 SHALL have port cfg_err  output  1  one-cycle pulse on rejected start.

Function
REQ-017 SHALL implement FSM states IDLE, UP, DOWN.
REQ-018 SHALL sample mode, f_start, f_stop, f_step and dwell into internal registers only on an accepted start; later input changes have no effect until the next accepted start.
REQ-019 SHALL accept start only in IDLE; start while busy is ignored.
REQ-020 SHALL reject start, pulse cfg_err next cycle, and remain in IDLE with Fcword unchanged, when f_step==0, f_start>f_stop, or mode==11.
REQ-021 SHALL, on accepted start in cycle n, present Fcword=f_start and busy=1 in cycle n+1 and enter UP.
REQ-022 SHALL hold each Fcword value for exactly dwell+1 cycles before stepping.
REQ-023 SHALL compute up-steps as cur+f_step in FW+1 bits, clamping to f_stop when the sum exceeds f_stop or overflows.
REQ-024 SHALL compute down-steps as cur-f_step in FW+1 bits, clamping to f_start when the result is below f_start or underflows.
REQ-025 SHALL, in UP with Fcword==f_stop and dwell expired, act as follows:
- mode 00: go IDLE; pulse done; busy=0 in the same cycle.
- mode 01: load f_start; pulse wrap.
- mode 10: enter DOWN; pulse wrap; step to f_stop-f_step, clamped.
REQ-026 SHALL, in DOWN with Fcword==f_start and dwell expired, enter UP, step upward, and pulse wrap.
REQ-027 SHALL treat f_start==f_stop as valid: the sweep holds one value; mode 10 alternates UP/DOWN each dwell, pulsing wrap.
REQ-028 SHALL, on abort while busy, enter IDLE next cycle with busy=0, Fcword holding its current value, and no done pulse.
REQ-029 SHALL give abort priority over start and over any same-cycle completion; abort in IDLE is a no-op.
REQ-030 SHALL keep Fcword constant in IDLE.

Reset
REQ-031 SHALL, on rst_n low, asynchronously force state=IDLE, Fcword=0, busy=0, done=0, wrap=0, cfg_err=0, dwell counter=0, and config registers=0.
REQ-032 SHALL, on reset assertion mid-sweep, discard the sweep; the first post-reset start follows REQ-021.

Structure
REQ-033 SHALL place the state typedef and mode encodings (MODE_SINGLE, MODE_SAW, MODE_TRI) in shared package dds_pkg.
REQ-034 SHALL implement dwell timing in one sub-module, dds_dwell_timer: load, count down, expire pulse.
REQ-035 SHALL keep all outputs registered, with no combinational input-to-output paths.

Verification
REQ-036 SHALL cover: mode 00, f_start=100, f_stop=400, f_step=100, dwell=2 -> Fcword 100,200,300,400, each 3 cycles; done one cycle after the 400 dwell.
REQ-037 SHALL cover: mode 00, f_start=100, f_stop=350, f_step=100, dwell=0 -> Fcword 100,200,300,350; then done.
REQ-038 SHALL cover: mode 10, f_start=0, f_stop=20, f_step=10, dwell=0 -> 0,10,20,10,0,10,...; wrap at each turnaround.
REQ-039 SHALL cover: f_start=FFFFFFF0h, f_stop=FFFFFFFFh, f_step=20h, mode 01 -> FFFFFFF0h, FFFFFFFFh, FFFFFFF0h, with no overflow wrap to low values.
REQ-040 SHALL cover: f_step=0 -> cfg_err pulse, busy stays 0; and start with abort in the same cycle -> no sweep.
REQ-041 SHALL cover: abort at the third step of a mode-01 sweep -> busy=0 next cycle, Fcword frozen, no done; and rst_n pulse mid-sweep -> Fcword=0 immediately.
